multicycle_sequencer: RTL and testbench

Parametrised multi-cycle control sequencer for the RV64 core; successor to the single-cycle top-level datapath. It holds the PC and an instruction register. It steps each instruction through FETCH, DECODE, EXECUTE, optional MEM and WB states, with ready/request handshakes to instruction and data memory. It also adds wait-state timeout, misaligned-target trapping and a retired-instruction counter. The existing fetch/decode/execute/memory/writeback datapath blocks hang off its strobes.

---
 rtl/multicycle_sequencer.sv | 169 ++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_sequencer
// Brief    : Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB control sequencer with
//            PC, instruction register, wait-state timeout, misaligned-target
//            trapping and a retired-instruction counter.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_sequencer #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = 4,
  parameter int              MAX_WAIT = 15,
  parameter int              CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             o_instr_req,
  output logic [XLEN-1:0]  o_instr_addr,
  input  logic             i_instr_ready,
  input  logic [31:0]      i_instr_rdata,
  output logic [31:0]      o_ir,
  output logic [XLEN-1:0]  o_pc,
  input  logic             i_stall,
  input  logic             i_branch_taken,
  input  logic [XLEN-1:0]  i_branch_target,
  input  logic             i_mem_access,
  output logic             o_data_req,
  input  logic             i_data_ready,
  input  logic             i_reg_write,
  output logic             o_rf_we,
  output logic             o_retire,
  output logic [CNT_W-1:0] o_retire_count,
  output logic [2:0]       o_state,
  output logic             o_err,
  output logic [1:0]       o_err_cause
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_ERROR  = 3'd7
  } state_t;

  localparam logic [31:0] c_NOP    = 32'h0000_0013;
  localparam int          WAIT_W   = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  // Count value reached after MAX_WAIT-1 low cycles; one more low cycle trips.
  localparam logic [WAIT_W-1:0] c_WAIT_LAST =
    WAIT_W'((MAX_WAIT > 0) ? (MAX_WAIT - 1) : 0);

  localparam logic [1:0] c_CAUSE_FETCH = 2'd1;
  localparam logic [1:0] c_CAUSE_DATA  = 2'd2;
  localparam logic [1:0] c_CAUSE_ALIGN = 2'd3;

  state_t            r_state;
  logic [XLEN-1:0]   r_pc;
  logic [31:0]       r_ir;
  logic [CNT_W-1:0]  r_retire_count;
  logic [WAIT_W-1:0] r_wait;
  logic              r_br_taken;
  logic [XLEN-1:0]   r_br_target;
  logic              r_err;
  logic [1:0]        r_err_cause;

  logic w_timeout;
  logic w_misaligned;

  // Timeout fires on the low cycle that completes MAX_WAIT consecutive waits.
  assign w_timeout    = (MAX_WAIT != 0) && (r_wait == c_WAIT_LAST);
  assign w_misaligned = i_branch_taken && (i_branch_target[1:0] != 2'b00);

  // Sequencer state, architectural registers and fault capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_pc           <= RESET_PC;
      r_ir           <= c_NOP;
      r_retire_count <= '0;
      r_wait         <= '0;
      r_br_taken     <= 1'b0;
      r_br_target    <= '0;
      r_err          <= 1'b0;
      r_err_cause    <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_wait  <= '0;
          r_state <= S_FETCH;
        end
        S_FETCH: begin
          if (i_instr_ready) begin
            r_ir    <= i_instr_rdata;
            r_state <= S_DECODE;
          end else if (w_timeout) begin
            r_state     <= S_ERROR;
            r_err       <= 1'b1;
            r_err_cause <= c_CAUSE_FETCH;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        S_DECODE: begin
          if (!i_stall) begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_br_taken  <= i_branch_taken;
          r_br_target <= i_branch_target;
          r_wait      <= '0;
          if (w_misaligned) begin
            r_state     <= S_ERROR;
            r_err       <= 1'b1;
            r_err_cause <= c_CAUSE_ALIGN;
          end else if (i_mem_access) begin
            r_state <= S_MEM;
          end else begin
            r_state <= S_WB;
          end
        end
        S_MEM: begin
          if (i_data_ready) begin
            r_state <= S_WB;
          end else if (w_timeout) begin
            r_state     <= S_ERROR;
            r_err       <= 1'b1;
            r_err_cause <= c_CAUSE_DATA;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        S_WB: begin
          r_pc           <= r_br_taken ? r_br_target : (r_pc + XLEN'(PC_STEP));
          r_retire_count <= r_retire_count + 1'b1;
          r_wait         <= '0;
          r_state        <= S_FETCH;
        end
        S_ERROR: begin
          r_state <= S_ERROR;
        end
        default: begin
          // Unused encoding: treat as a fault and park.
          r_state <= S_ERROR;
          r_err   <= 1'b1;
        end
      endcase
    end
  end

  // Strobes are pure state decodes so they can never leak outside their state.
  assign o_instr_req    = (r_state == S_FETCH);
  assign o_data_req     = (r_state == S_MEM);
  assign o_retire       = (r_state == S_WB);
  assign o_rf_we        = (r_state == S_WB) && i_reg_write;

  assign o_instr_addr   = r_pc;
  assign o_pc           = r_pc;
  assign o_ir           = r_ir;
  assign o_retire_count = r_retire_count;
  assign o_state        = r_state;
  assign o_err          = r_err;
  assign o_err_cause    = r_err_cause;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_sequencer
// Brief    : Randomised self-checking bench; an instruction-level reference
//            model predicts per-cycle state, strobes, pc, ir and counters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_sequencer;

  localparam int          XLEN     = 64;
  localparam logic [63:0] RESET_PC = 64'h0;
  localparam int          MAXW     = 15;
  localparam int          CNT_W    = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             o_instr_req;
  logic [XLEN-1:0]  o_instr_addr;
  logic             i_instr_ready = 1'b0;
  logic [31:0]      i_instr_rdata = '0;
  logic [31:0]      o_ir;
  logic [XLEN-1:0]  o_pc;
  logic             i_stall = 1'b0;
  logic             i_branch_taken = 1'b0;
  logic [XLEN-1:0]  i_branch_target = '0;
  logic             i_mem_access = 1'b0;
  logic             o_data_req;
  logic             i_data_ready = 1'b0;
  logic             i_reg_write = 1'b0;
  logic             o_rf_we;
  logic             o_retire;
  logic [CNT_W-1:0] o_retire_count;
  logic [2:0]       o_state;
  logic             o_err;
  logic [1:0]       o_err_cause;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: architectural view only
  logic [63:0] m_pc;
  logic [31:0] m_ir;
  int          m_cnt;

  multicycle_sequencer #(
    .XLEN(XLEN), .RESET_PC(RESET_PC), .PC_STEP(4), .MAX_WAIT(MAXW), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .o_instr_req(o_instr_req), .o_instr_addr(o_instr_addr),
    .i_instr_ready(i_instr_ready), .i_instr_rdata(i_instr_rdata),
    .o_ir(o_ir), .o_pc(o_pc), .i_stall(i_stall),
    .i_branch_taken(i_branch_taken), .i_branch_target(i_branch_target),
    .i_mem_access(i_mem_access), .o_data_req(o_data_req),
    .i_data_ready(i_data_ready), .i_reg_write(i_reg_write),
    .o_rf_we(o_rf_we), .o_retire(o_retire), .o_retire_count(o_retire_count),
    .o_state(o_state), .o_err(o_err), .o_err_cause(o_err_cause)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Unrelated inputs get random values every cycle.
  task automatic scramble();
    i_instr_ready   = 1'($urandom);
    i_instr_rdata   = $urandom;
    i_stall         = 1'($urandom);
    i_branch_taken  = 1'($urandom);
    i_branch_target = {$urandom, $urandom};
    i_mem_access    = 1'($urandom);
    i_data_ready    = 1'($urandom);
    i_reg_write     = 1'($urandom);
  endtask

  task automatic chk_cycle(input logic [2:0] st);
    chk("state", 64'(o_state), 64'(st));
    chk("instr_req", 64'(o_instr_req), 64'(st == 3'd1));
    chk("data_req", 64'(o_data_req), 64'(st == 3'd4));
    chk("retire", 64'(o_retire), 64'(st == 3'd5));
    if (st != 3'd5) chk("rf_we_idle", 64'(o_rf_we), 64'd0);
    chk("pc", o_pc, m_pc);
    chk("instr_addr", o_instr_addr, m_pc);
    chk("retire_count", 64'(o_retire_count), 64'(m_cnt));
    chk("err", 64'(o_err), 64'(st == 3'd7));
    if (st != 3'd7) chk("err_cause_none", 64'(o_err_cause), 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    m_pc  = RESET_PC;
    m_ir  = 32'h0000_0013;
    m_cnt = 0;
    chk("rst_state", 64'(o_state), 64'd0);
    chk("rst_pc", o_pc, RESET_PC);
    chk("rst_ir", 64'(o_ir), 64'h13);
    chk("rst_instr_req", 64'(o_instr_req), 64'd0);
    chk("rst_data_req", 64'(o_data_req), 64'd0);
    chk("rst_rf_we", 64'(o_rf_we), 64'd0);
    chk("rst_retire", 64'(o_retire), 64'd0);
    chk("rst_count", 64'(o_retire_count), 64'd0);
    chk("rst_err", 64'(o_err), 64'd0);
    chk("rst_cause", 64'(o_err_cause), 64'd0);
    step();
    #2;
    rst_n = 1'b1;
    chk_cycle(3'd0);
    step();
  endtask

  task automatic expect_error(input logic [1:0] cause);
    for (int k = 0; k < 4; k++) begin
      scramble();
      #1;
      chk_cycle(3'd7);
      chk("err_cause", 64'(o_err_cause), 64'(cause));
      chk("ir_frozen", 64'(o_ir), 64'(m_ir));
      step();
    end
  endtask

  // One instruction through the model. ended=1 means the DUT sits in ERROR.
  task automatic run_instr(input int fw, input int st, input bit tk, input logic [63:0] tg,
                           input bit mem, input int mw, input bit rw, input bit rmid,
                           output bit ended);
    logic [31:0] word;
    word  = $urandom;
    ended = 1'b0;
    for (int i = 0; ; i++) begin
      chk_cycle(3'd1);
      chk("ir_hold_fetch", 64'(o_ir), 64'(m_ir));
      scramble();
      i_instr_ready = (i == fw);
      i_instr_rdata = (i == fw) ? word : $urandom;
      step();
      if (i == fw) break;
      if (i == MAXW - 1) begin
        expect_error(2'd1);
        ended = 1'b1;
        return;
      end
    end
    m_ir = word;
    for (int i = 0; i <= st; i++) begin
      chk_cycle(3'd2);
      chk("ir_decode", 64'(o_ir), 64'(m_ir));
      scramble();
      i_stall = (i < st);
      step();
    end
    chk_cycle(3'd3);
    chk("ir_exec", 64'(o_ir), 64'(m_ir));
    scramble();
    i_branch_taken  = tk;
    i_branch_target = tg;
    i_mem_access    = mem;
    step();
    if (tk && tg[1:0] != 2'b00) begin
      expect_error(2'd3);
      ended = 1'b1;
      return;
    end
    if (mem) begin
      for (int i = 0; ; i++) begin
        chk_cycle(3'd4);
        chk("ir_mem", 64'(o_ir), 64'(m_ir));
        scramble();
        i_data_ready = (i == mw);
        if (rmid && i == 0) begin
          #2;
          do_reset();
          return;
        end
        step();
        if (i == mw) break;
        if (i == MAXW - 1) begin
          expect_error(2'd2);
          ended = 1'b1;
          return;
        end
      end
    end
    scramble();
    i_reg_write = rw;
    #1;
    chk_cycle(3'd5);
    chk("rf_we", 64'(o_rf_we), 64'(rw));
    chk("ir_wb", 64'(o_ir), 64'(m_ir));
    step();
    m_pc  = tk ? tg : m_pc + 64'd4;
    m_cnt = (m_cnt + 1) % (1 << CNT_W);
  endtask

  initial begin
    bit e;
    logic [63:0] tg;
    int r;
    #3;
    do_reset();

    // Straight-line, then a taken branch at pc=8
    run_instr(0, 0, 0, 64'h0, 0, 0, 1, 0, e);
    run_instr(0, 0, 0, 64'h0, 0, 0, 1, 0, e);
    chk("pc_before_branch", m_pc, 64'h8);
    run_instr(0, 0, 1, 64'h100, 0, 0, 1, 0, e);
    chk("instr_addr_after_branch", o_instr_addr, 64'h100);
    // Memory with 3 wait cycles, 5-cycle stall, fetch ready on 15th cycle
    run_instr(0, 0, 0, 64'h0, 1, 3, 1, 0, e);
    run_instr(0, 5, 0, 64'h0, 0, 0, 0, 0, e);
    run_instr(MAXW - 1, 0, 0, 64'h0, 0, 0, 1, 0, e);
    run_instr(0, 0, 0, 64'h0, 1, MAXW - 1, 1, 0, e);
    // PC wrap at the top of the address space
    run_instr(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 1, 0, e);
    run_instr(0, 0, 0, 64'h0, 0, 0, 1, 0, e);
    chk("pc_wrapped", o_pc, 64'h0);
    // Enough retires to wrap the 4-bit counter
    for (int n = 0; n < 10; n++)
      run_instr($urandom_range(0, 2), $urandom_range(0, 2), 0, 64'h0,
                1'($urandom), $urandom_range(0, 2), 1'($urandom), 0, e);
    chk("count_wrapped", 64'(o_retire_count), 64'd3);
    // Misaligned target
    run_instr(0, 0, 1, 64'h102, 0, 0, 1, 0, e);
    do_reset();
    // Fetch timeout
    run_instr(0, 0, 0, 64'h0, 0, 0, 1, 0, e);
    run_instr(MAXW, 0, 0, 64'h0, 0, 0, 1, 0, e);
    chk("fetch_timeout_pc", o_pc, 64'h4);
    do_reset();
    // Data timeout
    run_instr(0, 0, 0, 64'h0, 1, MAXW, 1, 0, e);
    do_reset();
    // Reset in the middle of MEM
    run_instr(0, 0, 0, 64'h0, 0, 0, 1, 0, e);
    run_instr(0, 0, 0, 64'h0, 1, 2, 1, 1, e);

    // Random instruction stream
    for (int n = 0; n < 300; n++) begin
      int fw, st, mw;
      bit tk, mem, rm;
      r   = $urandom_range(0, 99);
      fw  = (r < 20) ? $urandom_range(0, MAXW) : 0;
      st  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : 0;
      tk  = ($urandom_range(0, 3) == 0);
      tg  = {$urandom, $urandom} & ~64'h3;
      if ($urandom_range(0, 19) == 0) tg[1:0] = 2'($urandom_range(1, 3));
      mem = ($urandom_range(0, 2) == 0);
      mw  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, MAXW) : $urandom_range(0, 3);
      rm  = ($urandom_range(0, 29) == 0);
      run_instr(fw, st, tk, tg, mem, mw, 1'($urandom), rm, e);
      if (e) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
